// File: rtl/aes_cipher.sv
// ---------------------------------------------------------------------------
// aes_cipher -- iterative AES-128 encryption core, one round per clock.
//
// A block is accepted from IDLE when start and keys_valid are both high. The
// plaintext is whitened with round key 0 at that edge. The next ten edges
// each perform one full round, and the last round omits MixColumns. After the
// tenth round edge the result is loaded into ciphertext and done pulses for
// one cycle. Only one block is in flight at a time, and a start seen while
// busy is dropped.
//
// The round-key bank is not registered here. The key-expansion block must
// hold round_keys stable from the accepting edge to the done pulse.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (highest priority)
//   start       request to encrypt plaintext in the same cycle
//   keys_valid  round_keys complete and stable (key-expansion finish flag)
//   plaintext   128-bit input block, byte 0 = bits [127:120]
//   round_keys  11 x 128-bit round keys, key r = round_keys[1407-128*r -: 128]
//   ciphertext  128-bit result, held between done pulses
//   busy        encryption in progress
//   done        one-cycle pulse: ciphertext has just been updated
//
// Also contains sbox, the combinational AES S-box used by SubBytes.
// ---------------------------------------------------------------------------

module sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX_TABLE[a];
endmodule

module aes_cipher (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            keys_valid,
    input  logic [127:0]    plaintext,
    input  logic [1407:0]   round_keys,
    output logic [127:0]    ciphertext,
    output logic            busy,
    output logic            done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         fsm, fsm_d;
    logic [3:0]   rnd, rnd_d;
    logic [127:0] state, state_d;
    logic [127:0] ct_d;
    logic         busy_d, done_d;

    // GF(2^8) multiply by 2, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; byte of row 0 sits in the top 8 bits.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Round-key view. It is padded to 16 entries so every value of rnd selects
    // a defined word. rnd never exceeds 10, so the padding is never used.
    logic [127:0] rk [16];

    genvar gi, gc, gr;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rk
            if (gi < 11) begin : g_used
                assign rk[gi] = round_keys[1407-128*gi -: 128];
            end else begin : g_pad
                assign rk[gi] = '0;
            end
        end
    endgenerate

    // SubBytes: one S-box per state byte. Byte i is state[127-8*i -: 8] and
    // sits at row i%4, column i/4.
    logic [7:0] sb [16];
    logic [7:0] sr [16];

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            sbox u_sbox (
                .a (state[127-8*gi -: 8]),
                .s (sb[gi])
            );
        end

        // ShiftRows: row r rotates left by r, so the output at (r, c) takes the
        // input at (r, (c+r) mod 4).
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign sr[4*gc+gr] = sb[4*((gc+gr)%4)+gr];
            end
        end
    endgenerate

    logic [127:0] sr_blk, mc_blk, round_out;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign sr_blk[127-8*gi -: 8] = sr[gi];
        end
        for (gc = 0; gc < 4; gc++) begin : g_mix
            assign mc_blk[127-32*gc -: 32] = mix_col(sr_blk[127-32*gc -: 32]);
        end
    endgenerate

    // The final round skips MixColumns.
    assign round_out = (rnd == 4'd10) ? (sr_blk ^ rk[rnd]) : (mc_blk ^ rk[rnd]);

    // NOTE: every signal assigned here receives a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        fsm_d   = fsm;
        rnd_d   = rnd;
        state_d = state;
        ct_d    = ciphertext;
        busy_d  = busy;
        done_d  = 1'b0;

        case (fsm)
            IDLE: begin
                // A start without valid keys is dropped and leaves no trace.
                if (start && keys_valid) begin
                    state_d = plaintext ^ rk[0];
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                // start is not looked at here, so a request while busy is lost.
                state_d = round_out;
                if (rnd == 4'd10) begin
                    ct_d   = round_out;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    rnd_d  = 4'd0;
                    fsm_d  = IDLE;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, whatever order the simulator runs processes in.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            rnd        <= 4'd0;
            state      <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            fsm        <= fsm_d;
            rnd        <= rnd_d;
            state      <= state_d;
            ciphertext <= ct_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end
endmodule

// File: tb/tb_aes_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher -- directed test of aes_cipher with the FIPS-197 vectors.
// Round keys come from a behavioural key-expansion model. That model also
// stands in for the upstream key-expansion block, whose finish flag drives
// keys_valid.
// ---------------------------------------------------------------------------

module tb_aes_cipher;
    logic            clk;
    logic            rst;
    logic            start;
    logic            keys_valid;
    logic [127:0]    plaintext;
    logic [1407:0]   round_keys;
    logic [127:0]    ciphertext;
    logic            busy;
    logic            done;

    int total;
    int bad;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    aes_cipher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .keys_valid (keys_valid),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES-128 key schedule: 44 words, packed with round key 0 at the top.
    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] res;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {TB_SBOX[t[23:16]], TB_SBOX[t[15:8]], TB_SBOX[t[7:0]], TB_SBOX[t[31:24]]}
                    ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        res = '0;
        for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = w[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done is sampled high, within a bound. Returns the tick count
    // and whether ciphertext stayed at hold until done was sampled.
    task automatic wait_done(input logic [127:0] hold, output int n, output bit held);
        n    = 0;
        held = 1'b1;
        while (!done && n < 40) begin
            tick();
            n++;
            if (!done && ciphertext !== hold) held = 1'b0;
        end
    endtask

    initial begin
        int  n;
        bit  held;
        int  seen;
        int  dones;
        int  done_at;

        total = 0;
        bad   = 0;

        // Reset with start already high and the keys not yet valid.
        rst        = 1'b1;
        start      = 1'b1;
        keys_valid = 1'b0;
        plaintext  = PT_B;
        round_keys = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ct", ciphertext, 0);

        // Integration: the key expansion finishes a few cycles after reset.
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done) seen++;
        end
        check("kv_low_idle", seen, 0);
        round_keys = expand_key(KEY_B);
        keys_valid = 1'b1;               // finish rises here
        check("pre_accept_busy", busy, 0);
        tick();
        check("accept_after_finish", busy, 1);
        start     = 1'b0;
        plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        wait_done(128'h0, n, held);
        check("b_latency", n, 10);
        check("b_ct", ciphertext, CT_B);
        check("b_busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);

        // Back-to-back: first block App. B, then App. C.1 started in the
        // done cycle with its own keys and plaintext.
        plaintext = PT_B;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(CT_B, n, held);
        check("bb1_latency", n, 10);
        check("bb1_ct", ciphertext, CT_B);
        round_keys = expand_key(KEY_C);
        plaintext  = PT_C;
        start      = 1'b1;
        tick();
        check("bb2_accept_busy", busy, 1);
        check("bb2_accept_done", done, 0);
        start     = 1'b0;
        plaintext = 128'h0;
        wait_done(CT_B, n, held);
        check("bb2_latency", n + 1, 11);
        check("bb1_ct_held", held, 1);
        check("c1_ct", ciphertext, CT_C);

        // Start without valid keys is ignored.
        keys_valid = 1'b0;
        start      = 1'b1;
        seen       = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || done) seen++;
        end
        check("nokeys_ignored", seen, 0);
        check("nokeys_ct_kept", ciphertext, CT_C);

        // Starts at rnd=3 and rnd=7 are dropped; exactly one done follows.
        round_keys = expand_key(KEY_B);
        keys_valid = 1'b1;
        plaintext  = PT_B;
        tick();
        check("ign_accept_busy", busy, 1);
        start     = 1'b0;
        plaintext = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
        dones     = 0;
        done_at   = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (done) begin
                dones++;
                if (done_at == 0) done_at = k;
            end
            // After tick k the round counter holds 1+k.
            start = (k == 2 || k == 6);
        end
        start = 1'b0;
        check("ign_done_count", dones, 1);
        check("ign_done_at", done_at, 10);
        check("ign_ct", ciphertext, CT_B);
        check("ign_idle_after", busy, 0);

        // Reset at rnd=5 aborts the block and no done follows.
        plaintext = PT_C;
        round_keys = expand_key(KEY_C);
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();               // rnd is now 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ct", ciphertext, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // The first start after reset is accepted normally.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_accept", busy, 1);
        wait_done(128'h0, n, held);
        check("post_rst_latency", n, 10);
        check("post_rst_ct", ciphertext, CT_C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
